fc_feature_collector: RTL and testbench

FC_FEATURE_COLLECTOR -- requirements
Module: fc_feature_collector

---
 rtl/fc_feature_collector_pkg.sv | 19 +
 rtl/feature_bank_ram.sv | 49 ++++
 rtl/fc_feature_collector.sv | 182 ++++++++++++++++++
 tb/tb_fc_feature_collector.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fc_feature_collector_pkg.sv
// ---------------------------------------------------------------------------
// fc_feature_collector_pkg
// Shared NPU constants for the pooled-feature collector: feature width,
// pixels per frame, channel count, flattened feature count and the drain
// FSM state encoding.
// ---------------------------------------------------------------------------
package fc_feature_collector_pkg;

   localparam int unsigned CONV_BIT = 12;
   localparam int unsigned OUT_PIX  = 16;
   localparam int unsigned N_CH     = 3;
   localparam int unsigned FEAT_N   = N_CH * OUT_PIX;

   typedef enum logic {
      S_IDLE   = 1'b0,
      S_STREAM = 1'b1
   } drain_state_t;

endpackage

// File: rtl/feature_bank_ram.sv
// ---------------------------------------------------------------------------
// feature_bank_ram
// Two ping-pong banks of N_CH x OUT_PIX features. One write port stores all
// channel lanes of a pixel at once; one asynchronous read port returns a
// single flattened entry. Contents are not reset.
//
// Ports
//   clk        rising-edge clock
//   i_wr_en    write strobe
//   i_wr_bank  bank being filled
//   i_wr_pix   pixel pointer (raster order)
//   i_wr_data  channel lanes, lane 0 in the LSBs
//   i_rd_bank  bank being drained
//   i_rd_idx   flattened index, ch*OUT_PIX + pix
//   o_rd_data  entry at {i_rd_bank, i_rd_idx}
// ---------------------------------------------------------------------------
module feature_bank_ram #(
   parameter int unsigned  CONV_BIT = fc_feature_collector_pkg::CONV_BIT,
   parameter int unsigned  OUT_PIX  = fc_feature_collector_pkg::OUT_PIX,
   parameter int unsigned  N_CH     = fc_feature_collector_pkg::N_CH,
   localparam int unsigned FEAT_N   = N_CH * OUT_PIX,
   localparam int unsigned IDX_W    = $clog2(FEAT_N),
   localparam int unsigned PIX_W    = $clog2(OUT_PIX)
) (
   input  logic                     clk,
   input  logic                     i_wr_en,
   input  logic                     i_wr_bank,
   input  logic [PIX_W-1:0]         i_wr_pix,
   input  logic [N_CH*CONV_BIT-1:0] i_wr_data,
   input  logic                     i_rd_bank,
   input  logic [IDX_W-1:0]         i_rd_idx,
   output logic [CONV_BIT-1:0]      o_rd_data
);

   logic [CONV_BIT-1:0] r_mem [2][FEAT_N];

   // Channel-major layout: channel ch of pixel p lives at ch*OUT_PIX + p.
   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         for (int unsigned ch = 0; ch < N_CH; ch++) begin
            r_mem[i_wr_bank][IDX_W'(ch * OUT_PIX) + IDX_W'(i_wr_pix)] <=
               i_wr_data[ch*CONV_BIT +: CONV_BIT];
         end
      end
   end

   assign o_rd_data = r_mem[i_rd_bank][i_rd_idx];

endmodule

// File: rtl/fc_feature_collector.sv
// ---------------------------------------------------------------------------
// fc_feature_collector
// Collects pooled pixels (3 channels each) into ping-pong banks and streams
// each completed frame to the FC layer as FEAT_N flattened features in
// channel-major order over a valid/ready handshake.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   valid_in               one-cycle pulse: a pooled pixel is present
//   max_value_1..3         channel 1..3 values of that pixel
//   feat_data, feat_idx    flattened feature and its index (0..FEAT_N-1)
//   feat_valid, feat_ready output handshake
//   feat_last              high while feat_idx is FEAT_N-1
//   frame_done             one-cycle pulse after the final feature transfers
//   overflow, ovf_clr      sticky dropped-pixel flag and its clear
// ---------------------------------------------------------------------------
module fc_feature_collector #(
   parameter int unsigned  CONV_BIT = fc_feature_collector_pkg::CONV_BIT,
   parameter int unsigned  OUT_PIX  = fc_feature_collector_pkg::OUT_PIX,
   parameter int unsigned  N_CH     = fc_feature_collector_pkg::N_CH,
   localparam int unsigned FEAT_N   = N_CH * OUT_PIX,
   localparam int unsigned IDX_W    = $clog2(FEAT_N),
   localparam int unsigned PIX_W    = $clog2(OUT_PIX)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                valid_in,
   input  logic [CONV_BIT-1:0] max_value_1,
   input  logic [CONV_BIT-1:0] max_value_2,
   input  logic [CONV_BIT-1:0] max_value_3,
   output logic [CONV_BIT-1:0] feat_data,
   output logic [IDX_W-1:0]    feat_idx,
   output logic                feat_valid,
   input  logic                feat_ready,
   output logic                feat_last,
   output logic                frame_done,
   output logic                overflow,
   input  logic                ovf_clr
);

   import fc_feature_collector_pkg::*;

   drain_state_t        r_state, w_state_d;
   logic                r_feat_valid, w_feat_valid_d;
   logic [IDX_W-1:0]    r_feat_idx, w_feat_idx_d;
   logic [CONV_BIT-1:0] r_feat_data, w_feat_data_d;
   logic                r_feat_last, w_feat_last_d;
   logic                r_frame_done, w_frame_done_d;
   logic                r_overflow, w_overflow_d;
   logic [PIX_W-1:0]    r_wr_pix, w_wr_pix_d;
   logic                r_wr_bank, w_wr_bank_d;
   logic                r_rd_bank, w_rd_bank_d;
   logic [1:0]          r_full, w_full_d;

   logic                w_cap;
   logic                w_drop;
   logic                w_xfer;
   logic [IDX_W-1:0]    w_rd_idx;
   logic [CONV_BIT-1:0] w_rd_data;

   // Capture only goes to a non-full bank and drain only reads a full one,
   // so the two sides never touch the same bank at once.
   assign w_cap  = valid_in &  ~r_full[r_wr_bank];
   assign w_drop = valid_in &   r_full[r_wr_bank];
   assign w_xfer = r_feat_valid & feat_ready;

   // Look-ahead read: index 0 while idle, next index while streaming.
   assign w_rd_idx = (r_state == S_STREAM && !r_feat_last) ? r_feat_idx + IDX_W'(1) : '0;

   feature_bank_ram #(
      .CONV_BIT (CONV_BIT),
      .OUT_PIX  (OUT_PIX),
      .N_CH     (N_CH)
   ) u_bank_ram (
      .clk       (clk),
      .i_wr_en   (w_cap),
      .i_wr_bank (r_wr_bank),
      .i_wr_pix  (r_wr_pix),
      .i_wr_data ({max_value_3, max_value_2, max_value_1}),
      .i_rd_bank (r_rd_bank),
      .i_rd_idx  (w_rd_idx),
      .o_rd_data (w_rd_data)
   );

   always_comb begin
      w_state_d      = r_state;
      w_feat_valid_d = r_feat_valid;
      w_feat_idx_d   = r_feat_idx;
      w_feat_data_d  = r_feat_data;
      w_feat_last_d  = r_feat_last;
      w_frame_done_d = 1'b0;
      w_overflow_d   = r_overflow;
      w_wr_pix_d     = r_wr_pix;
      w_wr_bank_d    = r_wr_bank;
      w_rd_bank_d    = r_rd_bank;
      w_full_d       = r_full;

      // A new drop beats a simultaneous clear.
      if (w_drop) begin
         w_overflow_d = 1'b1;
      end else if (ovf_clr) begin
         w_overflow_d = 1'b0;
      end

      if (w_cap) begin
         if (r_wr_pix == PIX_W'(OUT_PIX - 1)) begin
            w_wr_pix_d          = '0;
            w_wr_bank_d         = ~r_wr_bank;
            w_full_d[r_wr_bank] = 1'b1;
         end else begin
            w_wr_pix_d = r_wr_pix + PIX_W'(1);
         end
      end

      unique case (r_state)
         S_IDLE: begin
            if (r_full[r_rd_bank]) begin
               w_state_d      = S_STREAM;
               w_feat_valid_d = 1'b1;
               w_feat_idx_d   = '0;
               w_feat_data_d  = w_rd_data;
               w_feat_last_d  = 1'b0;
            end
         end
         S_STREAM: begin
            if (w_xfer) begin
               if (r_feat_last) begin
                  w_state_d           = S_IDLE;
                  w_feat_valid_d      = 1'b0;
                  w_feat_idx_d        = '0;
                  w_feat_data_d       = '0;
                  w_feat_last_d       = 1'b0;
                  w_frame_done_d      = 1'b1;
                  w_full_d[r_rd_bank] = 1'b0;
                  w_rd_bank_d         = ~r_rd_bank;
               end else begin
                  w_feat_idx_d  = w_rd_idx;
                  w_feat_data_d = w_rd_data;
                  w_feat_last_d = (w_rd_idx == IDX_W'(FEAT_N - 1));
               end
            end
         end
         default: w_state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_feat_valid <= 1'b0;
         r_feat_idx   <= '0;
         r_feat_data  <= '0;
         r_feat_last  <= 1'b0;
         r_frame_done <= 1'b0;
         r_overflow   <= 1'b0;
         r_wr_pix     <= '0;
         r_wr_bank    <= 1'b0;
         r_rd_bank    <= 1'b0;
         r_full       <= '0;
      end else begin
         r_state      <= w_state_d;
         r_feat_valid <= w_feat_valid_d;
         r_feat_idx   <= w_feat_idx_d;
         r_feat_data  <= w_feat_data_d;
         r_feat_last  <= w_feat_last_d;
         r_frame_done <= w_frame_done_d;
         r_overflow   <= w_overflow_d;
         r_wr_pix     <= w_wr_pix_d;
         r_wr_bank    <= w_wr_bank_d;
         r_rd_bank    <= w_rd_bank_d;
         r_full       <= w_full_d;
      end
   end

   assign feat_valid = r_feat_valid;
   assign feat_idx   = r_feat_idx;
   assign feat_data  = r_feat_data;
   assign feat_last  = r_feat_last;
   assign frame_done = r_frame_done;
   assign overflow   = r_overflow;

endmodule

// File: tb/tb_fc_feature_collector.sv
// ---------------------------------------------------------------------------
// tb_fc_feature_collector
// Directed bench for fc_feature_collector: a table of single-frame scenarios
// plus hand-written back-to-back, overflow and mid-stream reset sequences.
// ---------------------------------------------------------------------------
module tb_fc_feature_collector;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        valid_in;
   logic [11:0] max_value_1, max_value_2, max_value_3;
   logic [11:0] feat_data;
   logic [5:0]  feat_idx;
   logic        feat_valid, feat_ready, feat_last, frame_done, overflow, ovf_clr;

   fc_feature_collector dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .valid_in    (valid_in),
      .max_value_1 (max_value_1),
      .max_value_2 (max_value_2),
      .max_value_3 (max_value_3),
      .feat_data   (feat_data),
      .feat_idx    (feat_idx),
      .feat_valid  (feat_valid),
      .feat_ready  (feat_ready),
      .feat_last   (feat_last),
      .frame_done  (frame_done),
      .overflow    (overflow),
      .ovf_clr     (ovf_clr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [11:0] data;
      logic [5:0]  idx;
      logic        last;
      int          cyc;
   } beat_t;

   typedef struct {
      logic [11:0] b1, b2, b3;
      int          rdy_mode;   // 1: ready held high, 2: random 50%
      bit          contig;
      logic [11:0] exp_first, exp_last;
   } vec_t;

   beat_t       beats[$];
   vec_t        tbl[4];
   int          n_checks = 0;
   int          n_pass = 0;
   int          cyc = 0;
   int          fd_total = 0;
   int          rdy_mode = 0;
   bit          stall_prev = 0;
   logic [11:0] sv_data;
   logic [5:0]  sv_idx;
   logic        sv_last;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Negedge monitor: record transfers, check hold during stalls.
   task automatic sample();
      if (stall_prev)
         chk("stall hold", 32'({feat_valid, feat_data, feat_idx, feat_last}),
             32'({1'b1, sv_data, sv_idx, sv_last}));
      if (feat_valid && feat_ready)
         beats.push_back('{data: feat_data, idx: feat_idx, last: feat_last, cyc: cyc});
      stall_prev = feat_valid && !feat_ready;
      sv_data    = feat_data;
      sv_idx     = feat_idx;
      sv_last    = feat_last;
      if (frame_done) fd_total++;
   endtask

   // One clock: sample at negedge, return 1ns after the rising edge.
   task automatic tick();
      @(negedge clk);
      sample();
      @(posedge clk);
      #1;
      cyc++;
      if (rdy_mode == 2) feat_ready = ($urandom_range(0, 1) == 1);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      stall_prev = 0;
      repeat (2) tick();
      chk("reset outputs", 32'({feat_valid, feat_data, feat_idx, feat_last, frame_done, overflow}),
          32'd0);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic send_frame(input logic [11:0] b1, input logic [11:0] b2,
                             input logic [11:0] b3, input int period, input bit lat);
      for (int p = 0; p < 16; p++) begin
         valid_in    = 1'b1;
         max_value_1 = b1 + 12'(p);
         max_value_2 = b2 + 12'(p);
         max_value_3 = b3 + 12'(p);
         tick();
         valid_in = 1'b0;
         if (p == 15 && lat) begin
            chk("valid low at 16th capture", 32'(feat_valid), 32'd0);
            tick();
            chk("first beat latency", 32'({feat_valid, feat_idx, feat_data}),
                32'({1'b1, 6'd0, b1}));
         end else if (p != 15) begin
            repeat (period - 1) tick();
         end
      end
   endtask

   task automatic wait_fd(input int target, input int budget);
      int n;
      n = 0;
      while (fd_total < target && n < budget) begin
         tick();
         n++;
      end
      chk("frame_done within budget", 32'(fd_total >= target), 32'd1);
   endtask

   task automatic check_frame(input int base, input logic [11:0] b1, input logic [11:0] b2,
                              input logic [11:0] b3, input bit contig);
      chk("frame beat count", 32'(beats.size() >= base + 48), 32'd1);
      if (beats.size() >= base + 48) begin
         for (int i = 0; i < 48; i++) begin
            logic [11:0] exp_d;
            case (i / 16)
               0:       exp_d = b1 + 12'(i % 16);
               1:       exp_d = b2 + 12'(i % 16);
               default: exp_d = b3 + 12'(i % 16);
            endcase
            chk($sformatf("beat %0d data/idx/last", i),
                32'({beats[base+i].data, beats[base+i].idx, beats[base+i].last}),
                32'({exp_d, 6'(i), (i == 47)}));
         end
         if (contig)
            chk("contiguous beats", 32'(beats[base+47].cyc - beats[base].cyc), 32'd47);
      end
   endtask

   initial begin
      int base;
      int fdb;
      rst_n       = 1'b0;
      valid_in    = 1'b0;
      max_value_1 = '0;
      max_value_2 = '0;
      max_value_3 = '0;
      feat_ready  = 1'b1;
      ovf_clr     = 1'b0;

      tbl[0] = '{b1: 12'd0,    b2: 12'd100,  b3: 12'd200,  rdy_mode: 1, contig: 1,
                 exp_first: 12'd0,    exp_last: 12'd215};
      tbl[1] = '{b1: 12'd0,    b2: 12'd100,  b3: 12'd200,  rdy_mode: 2, contig: 0,
                 exp_first: 12'd0,    exp_last: 12'd215};
      tbl[2] = '{b1: 12'hF00,  b2: 12'h7F0,  b3: 12'hFF0,  rdy_mode: 1, contig: 1,
                 exp_first: 12'hF00,  exp_last: 12'hFFF};
      tbl[3] = '{b1: 12'h0AA,  b2: 12'h555,  b3: 12'h800,  rdy_mode: 2, contig: 0,
                 exp_first: 12'h0AA,  exp_last: 12'h80F};

      do_reset();

      // Single-frame table (alternates banks 0/1 across records).
      for (int r = 0; r < 4; r++) begin
         rdy_mode   = tbl[r].rdy_mode;
         feat_ready = 1'b1;
         base = beats.size();
         fdb  = fd_total;
         send_frame(tbl[r].b1, tbl[r].b2, tbl[r].b3, 4, 1);
         wait_fd(fdb + 1, 400);
         repeat (3) tick();
         check_frame(base, tbl[r].b1, tbl[r].b2, tbl[r].b3, tbl[r].contig);
         if (beats.size() >= base + 48) begin
            chk("first data", 32'(beats[base].data), 32'(tbl[r].exp_first));
            chk("last data", 32'(beats[base+47].data), 32'(tbl[r].exp_last));
         end
         chk("one frame_done", 32'(fd_total - fdb), 32'd1);
         chk("no overflow", 32'(overflow), 32'd0);
      end
      rdy_mode   = 0;
      feat_ready = 1'b1;

      // Back-to-back: second frame fills bank 1 while bank 0 drains.
      do_reset();
      base = beats.size();
      fdb  = fd_total;
      send_frame(12'd0, 12'd100, 12'd200, 4, 0);
      send_frame(12'd300, 12'd400, 12'd500, 1, 0);
      wait_fd(fdb + 2, 300);
      check_frame(base, 12'd0, 12'd100, 12'd200, 1);
      check_frame(base + 48, 12'd300, 12'd400, 12'd500, 1);
      if (beats.size() >= base + 49)
         chk("one bubble between frames", 32'(beats[base+48].cyc - beats[base+47].cyc), 32'd2);
      chk("b2b overflow", 32'(overflow), 32'd0);

      // Overflow: three frames while stalled; third is dropped.
      do_reset();
      feat_ready = 1'b0;
      base = beats.size();
      fdb  = fd_total;
      send_frame(12'd0, 12'd100, 12'd200, 1, 0);
      send_frame(12'd300, 12'd400, 12'd500, 1, 0);
      chk("overflow after 32 px", 32'(overflow), 32'd0);
      for (int p = 0; p < 16; p++) begin
         valid_in    = 1'b1;
         ovf_clr     = (p == 1);
         max_value_1 = 12'd600 + 12'(p);
         max_value_2 = 12'd700 + 12'(p);
         max_value_3 = 12'd800 + 12'(p);
         tick();
         valid_in = 1'b0;
         ovf_clr  = 1'b0;
         if (p == 0) chk("overflow at 33rd px", 32'(overflow), 32'd1);
         if (p == 1) chk("set beats clear", 32'(overflow), 32'd1);
      end
      chk("no transfer while stalled", 32'(beats.size() - base), 32'd0);
      feat_ready = 1'b1;
      wait_fd(fdb + 2, 300);
      check_frame(base, 12'd0, 12'd100, 12'd200, 1);
      check_frame(base + 48, 12'd300, 12'd400, 12'd500, 1);
      chk("overflow sticky", 32'(overflow), 32'd1);
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      chk("overflow cleared", 32'(overflow), 32'd0);
      repeat (6) tick();
      chk("dropped frame not emitted", 32'(beats.size() - base), 32'd96);

      // Reset mid-stream at idx 20 with a partial frame in bank 1.
      do_reset();
      send_frame(12'd0, 12'd100, 12'd200, 1, 0);
      for (int p = 0; p < 5; p++) begin
         valid_in    = 1'b1;
         max_value_1 = 12'h111;
         max_value_2 = 12'h222;
         max_value_3 = 12'h333;
         tick();
      end
      valid_in = 1'b0;
      for (int n = 0; n < 60 && feat_idx != 6'd20; n++) tick();
      chk("reached idx 20", 32'(feat_idx), 32'd20);
      rst_n = 1'b0;
      #1;
      stall_prev = 0;
      chk("async reset outputs", 32'({feat_valid, feat_data, feat_idx, feat_last, frame_done,
                                      overflow}), 32'd0);
      tick();
      rst_n = 1'b1;
      base = beats.size();
      fdb  = fd_total;
      send_frame(12'd50, 12'd150, 12'd250, 4, 1);
      wait_fd(fdb + 1, 300);
      check_frame(base, 12'd50, 12'd150, 12'd250, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
